// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded RV32I fields from a valid/ready stream
// into 32-bit instruction words and writes them to consecutive imem slots,
// starting at BASE_ADDR for each session. A session ends after the word
// flagged in_last, or when the top of memory has been written.
// The compile-time macro ENC_RANGE_CHECK_EN enables immediate range checking.
// Without it, immediates are silently truncated and err_range stays 0.
//
// state  | meaning
// IDLE   | waiting for start
// ACCEPT | in_ready high, waiting for a field bundle
// WRITE  | mem_we high for the registered word, pointer advances
// DONE   | one-cycle done pulse, start accepted as in IDLE
module instr_encode_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_fmt,
  output logic              err_ovf,
  output logic              err_range
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              last_q;
  logic              we_q;
  logic              err_range_q;
  logic [31:0]       enc_word;
  logic              fmt_bad;
  logic              range_bad;
  logic [31:0]       slot_word;

  // Pack the incoming fields into the RV32I layout selected by in_fmt.
  always_comb begin
    enc_word = NOP;
    fmt_bad  = 1'b0;
    case (in_fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_opcode};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Flag immediates that would not survive truncation to their field width.
  always_comb begin
    range_bad = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: range_bad = (in_imm != {{20{in_imm[11]}}, in_imm[11:0]});
      FMT_B:        range_bad = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
      FMT_J:        range_bad = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
      FMT_U:        range_bad = |in_imm[11:0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  // Rejected bundles still occupy their slot, filled with a nop.
  assign slot_word = (fmt_bad || range_bad) ? NOP : enc_word;

  // A reset landing on the write cycle must not reach imem.
  assign mem_we    = we_q & ~reset;
  assign err_range = err_range_q;

  // Session sequencer with registered handshake, strobe and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      we_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= '0;
      count       <= '0;
      err_fmt     <= 1'b0;
      err_ovf     <= 1'b0;
      err_range_q <= 1'b0;
      ptr         <= BASE_ADDR;
      last_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state       <= ACCEPT;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            count       <= '0;
            err_fmt     <= 1'b0;
            err_ovf     <= 1'b0;
            err_range_q <= 1'b0;
            ptr         <= BASE_ADDR;
          end else begin
            state <= IDLE;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            mem_wdata <= slot_word;
            mem_addr  <= ptr;
            last_q    <= in_last;
            in_ready  <= 1'b0;
            we_q      <= 1'b1;
            if (fmt_bad)   err_fmt     <= 1'b1;
            if (range_bad) err_range_q <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          we_q  <= 1'b0;
          count <= count + 1'b1;
          ptr   <= ptr + 1'b1;
          if (last_q) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (ptr == '1) begin
            err_ovf <= 1'b1;
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: one default instance (ADDR_W=8)
// and one small instance (ADDR_W=2) for the memory-full case.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset, start, start2, in_valid, in_last;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_we, busy, done, err_fmt, err_ovf, err_range;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        in_ready2, mem_we2, busy2, done2, err_fmt2, err_ovf2, err_range2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  int n_tests = 0;
  int n_fail  = 0;
  int wr1 = 0, wr2 = 0, rdy_viol = 0;

  always #5 clk = ~clk;

  instr_encode_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .count(count), .err_fmt(err_fmt), .err_ovf(err_ovf), .err_range(err_range)
  );

  instr_encode_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2), .done(done2),
    .count(count2), .err_fmt(err_fmt2), .err_ovf(err_ovf2), .err_range(err_range2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Count strobes per instance; in_ready must never coincide with a write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) wr1++;
    if (mem_we2 === 1'b1) wr2++;
    if ((mem_we && in_ready) || (mem_we2 && in_ready2)) rdy_viol++;
  end

  task automatic reset_chk(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_mem_we"}, mem_we, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_addr"}, mem_addr, 0);
    check_val({tag, "_wdata"}, mem_wdata, 0);
    check_val({tag, "_count"}, count, 0);
    check_val({tag, "_errs"}, {err_fmt, err_ovf, err_range}, 0);
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    check_val("busy_after_start", sel ? busy2 : busy, 1);
  endtask

  task automatic send(input bit sel, input logic [2:0] f, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm,
                      input bit last, input int gap, input logic [7:0] exp_addr,
                      input logic [31:0] exp_data);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    t = 0;
    while (!(sel ? in_ready2 : in_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("handshake_wait", (t < 20), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("we_after_accept", sel ? mem_we2 : mem_we, 1);
    check_val("ready_low_in_write", sel ? in_ready2 : in_ready, 0);
    check_val("write_addr", sel ? {6'b0, mem_addr2} : mem_addr, exp_addr);
    check_val("write_data", sel ? mem_wdata2 : mem_wdata, exp_data);
  endtask

  task automatic finish_chk(input bit sel, input int exp_count, input bit exp_ovf,
                            input bit exp_fmt);
    @(posedge clk);
    #1;
    check_val("done_pulse", sel ? done2 : done, 1);
    check_val("busy_in_done", sel ? busy2 : busy, 0);
    check_val("count", sel ? {29'b0, count2} : {23'b0, count}, exp_count);
    check_val("err_ovf", sel ? err_ovf2 : err_ovf, exp_ovf);
    check_val("err_fmt", sel ? err_fmt2 : err_fmt, exp_fmt);
    @(posedge clk);
    #1;
    check_val("done_one_cycle", sel ? done2 : done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_chk("rst");
    check_val("rst_small", {in_ready2, mem_we2, busy2, done2, count2, mem_addr2}, 0);
    reset = 1'b0;

    // addi x1, x0, 5
    pulse_start(0);
    send(0, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 0, 8'd0, 32'h0050_0093);
    finish_chk(0, 1, 0, 0);

    // sw x2, 8(x1); beq x0, x0, -4
    pulse_start(0);
    send(0, 3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 0, 8'd0, 32'h0020_A423);
    send(0, 3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1, 0, 8'd1, 32'hFE00_0EE3);
    finish_chk(0, 2, 0, 0);

    // jal x1, 8; lui x5, 0x12345 with idle gaps on in_valid
    pulse_start(0);
    send(0, 3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 0, 3, 8'd0, 32'h0080_00EF);
    send(0, 3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1, 2, 8'd1, 32'h1234_52B7);
    finish_chk(0, 2, 0, 0);
    check_val("writes_so_far", wr1, 5);

    // invalid fmt mid-stream, then sub x1, x2, x3
    pulse_start(0);
    send(0, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 8'd0, 32'h0050_0093);
    send(0, 3'd7, 7'b1111111, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 0, 0, 8'd1, 32'h0000_0013);
    send(0, 3'd0, 7'b0110011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 1, 0, 8'd2, 32'h4031_00B3);
    finish_chk(0, 3, 0, 1);

    // new session clears sticky errors; I imm=2048 is out of 12-bit range
    pulse_start(0);
    check_val("err_fmt_cleared", err_fmt, 0);
`ifdef ENC_RANGE_CHECK_EN
    send(0, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 0, 8'd0, 32'h0000_0013);
    finish_chk(0, 1, 0, 0);
    check_val("err_range", err_range, 1);
`else
    send(0, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 0, 8'd0, 32'h8000_0093);
    finish_chk(0, 1, 0, 0);
    check_val("err_range", err_range, 0);
`endif

    // 4-word memory, no last: fills and stops with err_ovf
    pulse_start(1);
    for (int k = 0; k < 4; k++)
      send(1, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k + 1), 0, 0,
           8'(k), (32'(k + 1) << 20) | 32'h93);
    finish_chk(1, 4, 1, 0);
    @(negedge clk);
    in_fmt = 3'd1; in_imm = 32'd9; in_last = 1'b0; in_valid = 1'b1;
    repeat (8) @(negedge clk);
    check_val("fifth_not_ready", in_ready2, 0);
    in_valid = 1'b0;
    check_val("small_writes", wr2, 4);

    // reset during the write cycle suppresses the strobe
    pulse_start(0);
    send(0, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 0, 0, 8'd0, 32'h0010_0093);
    reset = 1'b1;
    #1;
    check_val("we_masked_by_reset", mem_we, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_chk("midrst");
    pulse_start(0);
    check_val("restart_count", count, 0);
    send(0, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 0, 8'd0, 32'h0050_0093);
    finish_chk(0, 1, 0, 0);
    check_val("total_writes", wr1, 10);
    check_val("ready_write_overlap", rdy_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
